// File: rtl/phy_rx_s2p.sv
// Serial-to-parallel receive stage: hunts for COM, locks after LOCK_COUNT
// aligned COMs, then emits non-IDLE/non-COM bytes with a slot-wide valid flag.
module phy_rx_s2p #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    ACTIVE
  } state_t;

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  state_t     state, state_nx;
  logic [7:0] sr, sr_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [3:0] com_cnt, com_cnt_nx;
  logic [7:0] data_nx;
  logic       valid_nx;
  logic       strobe_nx;
  logic       active_nx;
  logic       boundary;

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state       <= SEARCH;
      sr          <= '0;
      bit_cnt     <= '0;
      com_cnt     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nx;
      sr          <= sr_nx;
      bit_cnt     <= bit_cnt_nx;
      com_cnt     <= com_cnt_nx;
      data_out    <= data_nx;
      valid_out   <= valid_nx;
      byte_strobe <= strobe_nx;
      active      <= active_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sr_nx      = {sr[6:0], data_in};
    bit_cnt_nx = bit_cnt;
    com_cnt_nx = com_cnt;
    data_nx    = data_out;
    valid_nx   = valid_out;
    strobe_nx  = 1'b0;
    active_nx  = active;
    boundary   = (bit_cnt == 3'd7);

    case (state)
      SEARCH: begin
        // Bit-wise hunt: a match here defines the byte alignment from now on.
        if (sr_nx == COM) begin
          com_cnt_nx = 4'd1;
          bit_cnt_nx = '0;
          if (LOCK_COUNT == 1) begin
            state_nx  = ACTIVE;
            active_nx = 1'b1;
          end else begin
            state_nx = LOCKING;
          end
        end
      end

      LOCKING: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          if (sr_nx == COM) begin
            if (com_cnt + 4'd1 == LOCK_CNT4) begin
              state_nx  = ACTIVE;
              active_nx = 1'b1;
            end else begin
              com_cnt_nx = com_cnt + 4'd1;
            end
          end else begin
            state_nx   = SEARCH;
            com_cnt_nx = '0;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          strobe_nx = 1'b1;
          if (sr_nx == IDLE || sr_nx == COM) begin
            valid_nx = 1'b0;
          end else begin
            data_nx  = sr_nx;
            valid_nx = 1'b1;
          end
        end
      end

      default: begin
        state_nx = SEARCH;
      end
    endcase
  end

endmodule

// File: tb/tb_phy_rx_s2p.sv
// Directed bench for phy_rx_s2p: default LOCK_COUNT instance plus a
// LOCK_COUNT=1 instance sharing clock, reset and serial input.
module tb_phy_rx_s2p;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       din     = 1'b0;
  logic [7:0] d0, d1;
  logic       v0, v1, s0, s1, a0, a1;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned strobes;

  always #5 clk_32f = ~clk_32f;

  phy_rx_s2p #(.LOCK_COUNT(4)) u0 (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (din),
    .data_out    (d0),
    .valid_out   (v0),
    .byte_strobe (s0),
    .active      (a0)
  );

  phy_rx_s2p #(.LOCK_COUNT(1)) u1 (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (din),
    .data_out    (d1),
    .valid_out   (v1),
    .byte_strobe (s1),
    .active      (a1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk_32f);
    #1;
  endtask

  // MSB first; returns how many cycles u0's byte_strobe was seen high.
  task automatic send_byte(input logic [7:0] b, output int unsigned n);
    n = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (s0) n++;
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    din     = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_data", d0, 8'h00);
    chk("rst_valid", {7'd0, v0}, 8'd0);
    chk("rst_strobe", {7'd0, s0}, 8'd0);
    chk("rst_active", {7'd0, a0}, 8'd0);
    chk("rst_active1", {7'd0, a1}, 8'd0);

    // Aligned lock, then AA, 55
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC, strobes);
      chk("lock_pre_active", {7'd0, a0}, 8'd0);
      chk("lock_pre_strobes", 8'(strobes), 8'd0);
    end
    send_byte(8'hBC, strobes);
    chk("lock_active", {7'd0, a0}, 8'd1);
    chk("lock_strobe_lo", {7'd0, s0}, 8'd0);
    chk("lock_valid_lo", {7'd0, v0}, 8'd0);
    send_byte(8'hAA, strobes);
    chk("aa_data", d0, 8'hAA);
    chk("aa_valid", {7'd0, v0}, 8'd1);
    chk("aa_strobe", {7'd0, s0}, 8'd1);
    chk("aa_strobes", 8'(strobes), 8'd1);
    send_byte(8'h55, strobes);
    chk("55_data", d0, 8'h55);
    chk("55_valid", {7'd0, v0}, 8'd1);
    chk("55_strobes", 8'(strobes), 8'd1);
    send_bit(1'b0);
    chk("strobe_one_cycle", {7'd0, s0}, 8'd0);
    chk("valid_held", {7'd0, v0}, 8'd1);

    // Unaligned hunt after junk bits
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 3; k++) send_byte(8'hBC, strobes);
    chk("junk_pre_active", {7'd0, a0}, 8'd0);
    send_byte(8'hBC, strobes);
    chk("junk_active", {7'd0, a0}, 8'd1);
    send_byte(8'hFF, strobes);
    chk("ff_data", d0, 8'hFF);
    chk("ff_valid", {7'd0, v0}, 8'd1);

    // Broken lock sequence
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC, strobes);
      chk("brk_active", {7'd0, a0}, 8'd0);
      chk("brk_valid", {7'd0, v0}, 8'd0);
    end
    send_byte(8'h00, strobes);
    chk("brk00_active", {7'd0, a0}, 8'd0);
    chk("brk00_valid", {7'd0, v0}, 8'd0);
    send_byte(8'hBC, strobes);
    chk("brkbc_active", {7'd0, a0}, 8'd0);
    chk("brkbc_valid", {7'd0, v0}, 8'd0);
    chk("brk_strobes", 8'(strobes), 8'd0);

    // IDLE/COM filtering while active
    do_reset();
    for (int k = 0; k < 4; k++) send_byte(8'hBC, strobes);
    chk("flt_active", {7'd0, a0}, 8'd1);
    send_byte(8'hDD, strobes);
    chk("dd_data", d0, 8'hDD);
    chk("dd_valid", {7'd0, v0}, 8'd1);
    send_byte(8'h7C, strobes);
    chk("idle_data", d0, 8'hDD);
    chk("idle_valid", {7'd0, v0}, 8'd0);
    chk("idle_strobe", {7'd0, s0}, 8'd1);
    send_byte(8'hBC, strobes);
    chk("com_data", d0, 8'hDD);
    chk("com_valid", {7'd0, v0}, 8'd0);
    chk("com_active", {7'd0, a0}, 8'd1);
    send_byte(8'hCC, strobes);
    chk("cc_data", d0, 8'hCC);
    chk("cc_valid", {7'd0, v0}, 8'd1);

    // Mid-byte reset while active, then relock
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_L = 1'b0;
    din     = 1'b0;
    @(posedge clk_32f);
    #1;
    chk("mrst_active", {7'd0, a0}, 8'd0);
    chk("mrst_valid", {7'd0, v0}, 8'd0);
    chk("mrst_data", d0, 8'h00);
    chk("mrst_strobe", {7'd0, s0}, 8'd0);
    reset_L = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(8'hBC, strobes);
    chk("relock_pre", {7'd0, a0}, 8'd0);
    send_byte(8'hBC, strobes);
    chk("relock_active", {7'd0, a0}, 8'd1);

    // LOCK_COUNT=1 instance
    do_reset();
    send_byte(8'hBC, strobes);
    chk("lc1_active", {7'd0, a1}, 8'd1);
    chk("lc1_strobe_lo", {7'd0, s1}, 8'd0);
    chk("lc1_u0_active", {7'd0, a0}, 8'd0);
    send_byte(8'h11, strobes);
    chk("lc1_data", d1, 8'h11);
    chk("lc1_valid", {7'd0, v1}, 8'd1);
    chk("lc1_strobe", {7'd0, s1}, 8'd1);
    chk("lc1_u0_valid", {7'd0, v0}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
